// File: rtl/comp_sum_feeder.sv
// comp_sum_feeder: packs up to four 16-bit words into the operand registers of a
// 4-input summer, then collects the summer's 17-bit result under valid/ready.
module comp_sum_feeder #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] val1,
  output logic [15:0] val2,
  output logic [15:0] val3,
  output logic [15:0] val4,
  input  logic [15:0] sum_in,
  input  logic        carry_in,
  output logic [16:0] res_data,
  output logic [2:0]  res_count,
  output logic        res_valid,
  input  logic        res_ready
);

  typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] slot [4];
  logic [1:0]  idx;
  logic [2:0]  count;
  logic [2:0]  wait_cnt;
  logic        accept;
  logic        group_done;
  logic        capture;
  logic        release_res;

  assign in_ready    = (state == FILL) && !reset;
  assign accept      = in_valid && in_ready;
  assign group_done  = accept && (in_last || idx == 2'd3);
  assign capture     = (state == WAIT) && (wait_cnt == 3'd0);
  assign release_res = (state == HOLD) && res_ready;

  assign val1 = slot[0];
  assign val2 = slot[1];
  assign val3 = slot[2];
  assign val4 = slot[3];

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (group_done) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Operands stay put from the last accept until the result is taken, so the
  // summer sees a stable group regardless of its latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      idx       <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      res_data  <= '0;
      res_count <= '0;
      res_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        slot[idx] <= in_data;
        idx       <= idx + 2'd1;
        count     <= count + 3'd1;
      end
      if (group_done) begin
        wait_cnt <= LAT_CNT;
      end else if (state == WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (capture) begin
        res_data  <= {carry_in, sum_in};
        res_count <= count;
        res_valid <= 1'b1;
      end
      if (release_res) begin
        for (int i = 0; i < 4; i++) slot[i] <= '0;
        idx       <= '0;
        count     <= '0;
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comp_sum_feeder.sv
// tb_comp_sum_feeder: drives word groups into comp_sum_feeder with a pipelined
// summer model attached and compares results against a plain-arithmetic group model.
module tb_comp_sum_feeder;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] val1, val2, val3, val4;
  logic [15:0] sum_in;
  logic        carry_in;
  logic [16:0] res_data;
  logic [2:0]  res_count;
  logic        res_valid;
  logic        res_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  comp_sum_feeder #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .val1(val1), .val2(val2), .val3(val3), .val4(val4),
    .sum_in(sum_in), .carry_in(carry_in),
    .res_data(res_data), .res_count(res_count), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream summer: LAT register stages of the 17-bit sum.
  logic [16:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= 17'(val1) + 17'(val2) + 17'(val3) + 17'(val4);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sum_in   = pipe[LAT-1][15:0];
  assign carry_in = pipe[LAT-1][16];

  always @(posedge clk) cyc++;

  bit          prev_rv = 1'b0;
  int          rise_cyc[$];
  logic [16:0] rise_data[$];
  always @(negedge clk) begin
    if (res_valid === 1'b1 && !prev_rv) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(res_data);
    end
    prev_rv = (res_valid === 1'b1);
  end

  function automatic logic [16:0] ref_sum(input logic [3:0][15:0] w, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(w[i]);
    return 17'(s & 32'h1FFFF);
  endfunction

  function automatic logic [63:0] ref_vals(input logic [3:0][15:0] w, input int n);
    logic [3:0][15:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = w[i];
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic drive_word(input logic [15:0] w, input bit last, output bit ok);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    ok       = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_group(input logic [3:0][15:0] w, input int n, input int gap,
                           output logic [63:0] v, output int lat,
                           output logic [16:0] d, output logic [2:0] c, output bit ok);
    bit o;
    int g;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      drive_word(w[i], i == n - 1, o);
      ok &= o;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    v   = {val4, val3, val2, val1};
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = res_data;
    c = res_count;
  endtask

  task automatic take_result(output bit rv, output bit ir, output logic [63:0] v);
    res_ready = 1'b1;
    @(negedge clk);
    rv = res_valid;
    ir = in_ready;
    v  = {val4, val3, val2, val1};
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if ({val4, val3, val2, val1} !== 64'h0) begin errors++; $display("[TB] FAIL reset_vals: got %h expected 0", {val4, val3, val2, val1}); end
    checks++; if (res_data !== 17'h0) begin errors++; $display("[TB] FAIL reset_res_data: got %h expected 0", res_data); end
    checks++; if (res_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_res_count: got %0d expected 0", res_count); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // Table of directed groups: basic, short, single, wrap-around, bubbles.
  task automatic test_directed;
    logic [3:0][15:0] w [6];
    int n [6];
    int gap [6];
    logic [16:0] ed [6];
    logic [63:0] v, va;
    logic [16:0] d;
    logic [2:0]  c;
    int lat;
    bit ok, rv, ir;
    w[0] = {16'd4, 16'd3, 16'd2, 16'd1};                 n[0] = 4; gap[0] = 0; ed[0] = 17'h0000A;
    w[1] = {16'h0, 16'h0, 16'h0001, 16'h1234};           n[1] = 2; gap[1] = 0; ed[1] = 17'h01235;
    w[2] = {16'h0, 16'h0, 16'h0, 16'h00FF};              n[2] = 1; gap[2] = 0; ed[2] = 17'h000FF;
    w[3] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};     n[3] = 4; gap[3] = 0; ed[3] = 17'h1FFFC;
    w[4] = {16'h8000, 16'h8000, 16'h8000, 16'h8000};     n[4] = 4; gap[4] = 0; ed[4] = 17'h00000;
    w[5] = {16'd11, 16'd9, 16'd7, 16'd5};                n[5] = 4; gap[5] = 2; ed[5] = 17'h00020;
    for (int t = 0; t < 6; t++) begin
      run_group(w[t], n[t], gap[t], v, lat, d, c, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL directed%0d_accept: got timeout expected accept", t); end
      checks++; if (v !== ref_vals(w[t], n[t])) begin errors++; $display("[TB] FAIL directed%0d_vals: got %h expected %h", t, v, ref_vals(w[t], n[t])); end
      checks++; if (lat !== LAT + 1) begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", t, lat, LAT + 1); end
      checks++; if (d !== ed[t]) begin errors++; $display("[TB] FAIL directed%0d_res_data: got %h expected %h", t, d, ed[t]); end
      checks++; if (c !== 3'(n[t])) begin errors++; $display("[TB] FAIL directed%0d_res_count: got %0d expected %0d", t, c, n[t]); end
      take_result(rv, ir, va);
      checks++; if (rv !== 1'b0 || ir !== 1'b1 || va !== 64'h0) begin errors++; $display("[TB] FAIL directed%0d_release: got rv=%b ir=%b vals=%h expected rv=0 ir=1 vals=0", t, rv, ir, va); end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0][15:0] w;
    logic [63:0] v;
    logic [16:0] d, ed;
    logic [2:0]  c;
    int lat;
    bit ok, bad;
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    ed = ref_sum(w, 4);
    run_group(w, 4, 0, v, lat, d, c, ok);
    checks++; if (d !== ed) begin errors++; $display("[TB] FAIL bp_res_data: got %h expected %h", d, ed); end
    in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== ed || in_ready !== 1'b0 || {val4, val3, val2, val1} !== v) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("[TB] FAIL bp_hold_stable: got rv=%b data=%h ir=%b expected rv=1 data=%h ir=0", res_valid, res_data, in_ready, ed); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got rv=%b ir=%b expected rv=0 ir=1", res_valid, in_ready); end
    checks++; if ({val4, val3, val2, val1} !== 64'h0) begin errors++; $display("[TB] FAIL bp_vals_clear: got %h expected 0", {val4, val3, val2, val1}); end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (val1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL bp_first_word: got %h expected beef", val1); end
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (res_data !== 17'h0BEEF || res_count !== 3'd1) begin errors++; $display("[TB] FAIL bp_followup: got %h/%0d expected 0beef/1", res_data, res_count); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int seen;
    logic [3:0][15:0] w;
    logic [63:0] v;
    logic [16:0] d;
    logic [2:0]  c;
    int lat;
    drive_word(16'd1, 1'b0, ok);
    drive_word(16'd2, 1'b0, ok);
    drive_word(16'd3, 1'b1, ok);
    in_valid = 1'b0; in_last = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({val4, val3, val2, val1} !== 64'h0 || res_data !== 17'h0 || res_count !== 3'd0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got vals=%h data=%h cnt=%0d rv=%b ir=%b expected all 0", {val4, val3, val2, val1}, res_data, res_count, res_valid, in_ready);
    end
    reset = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (res_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midreset_no_pulse: got %0d valid cycles expected 0", seen); end
    w = {16'h0, 16'h0, 16'd20, 16'd10};
    run_group(w, 2, 0, v, lat, d, c, ok);
    checks++; if (d !== 17'h0001E || c !== 3'd2) begin errors++; $display("[TB] FAIL midreset_next_group: got %h/%0d expected 0001e/2", d, c); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0][15:0] w;
    logic [16:0] exp_q[$];
    bit ok, all_ok;
    int waited;
    rise_cyc.delete();
    rise_data.delete();
    res_ready = 1'b1;
    all_ok = 1'b1;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
      exp_q.push_back(ref_sum(w, 4));
      for (int i = 0; i < 4; i++) begin
        drive_word(w[i], i == 3, ok);
        all_ok &= ok;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    waited = 0;
    while (rise_cyc.size() < 3 && waited < 60) begin @(negedge clk); waited++; end
    repeat (2) @(negedge clk);
    res_ready = 1'b0;
    checks++; if (!all_ok || rise_cyc.size() != 3) begin errors++; $display("[TB] FAIL b2b_results: got %0d results expected 3", rise_cyc.size()); end
    for (int i = 0; i < 3 && i < rise_cyc.size(); i++) begin
      checks++; if (rise_data[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, rise_data[i], exp_q[i]); end
      if (i > 0) begin
        checks++; if (rise_cyc[i] - rise_cyc[i-1] != LAT + 6) begin errors++; $display("[TB] FAIL b2b_period%0d: got %0d expected %0d", i, rise_cyc[i] - rise_cyc[i-1], LAT + 6); end
      end
    end
  endtask

  task automatic test_random;
    logic [3:0][15:0] w;
    logic [63:0] v, va;
    logic [16:0] d;
    logic [2:0]  c;
    int n, lat;
    bit ok, rv, ir;
    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) w[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      run_group(w, n, -1, v, lat, d, c, ok);
      checks++; if (!ok || v !== ref_vals(w, n)) begin errors++; $display("[TB] FAIL rand%0d_vals: got %h expected %h", t, v, ref_vals(w, n)); end
      checks++; if (lat !== LAT + 1) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", t, lat, LAT + 1); end
      checks++; if (d !== ref_sum(w, n) || c !== 3'(n)) begin errors++; $display("[TB] FAIL rand%0d_result: got %h/%0d expected %h/%0d", t, d, c, ref_sum(w, n), n); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_result(rv, ir, va);
      checks++; if (rv !== 1'b0 || ir !== 1'b1 || va !== 64'h0) begin errors++; $display("[TB] FAIL rand%0d_release: got rv=%b ir=%b vals=%h expected rv=0 ir=1 vals=0", t, rv, ir, va); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting comp_sum_feeder bench, LAT=%0d", LAT);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
